// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;
endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; 2 clk latency,
// no backpressure. Reset value is a parameter so idle-high lines stay quiet.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver sampling mid-bit on an oversampled tick; byte out on the stop-sample edge.
// One-entry holding register with valid/ready; a full register drops the new frame and pulses overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sample_tick,
  input  logic                 i_en,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data_out,
  output logic                 o_data_valid,
  input  logic                 i_data_ready,
  output logic                 o_frame_err,
  output logic                 o_overrun
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 w_rx_s;
  logic [CW-1:0]        w_cnt_nxt;
  logic                 w_free;

  uart_state_e          r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_rx_prev;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_data_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync_rx (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (w_rx_s)
  );

  assign w_cnt_nxt = r_cnt + 1'b1;
  // Holding register can take a byte if empty or being drained this cycle.
  assign w_free    = !r_data_valid || i_data_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_rx_prev    <= 1'b1;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (r_data_valid && i_data_ready) r_data_valid <= 1'b0;
      if (i_sample_tick) r_rx_prev <= w_rx_s;

      if (!i_en) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (i_sample_tick) begin
        case (r_state)
          IDLE: begin
            if (r_rx_prev && !w_rx_s) begin
              r_cnt   <= '0;
              r_state <= START;
            end
          end
          START: begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == HALF_M1) begin
              if (w_rx_s) begin
                r_state <= IDLE;
              end else begin
                r_cnt     <= '0;
                r_bit_idx <= '0;
                r_state   <= DATA;
              end
            end
          end
          DATA: begin
            r_cnt <= w_cnt_nxt;
            if (r_cnt == LAST_CNT) begin
              r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
              r_cnt     <= '0;
              r_bit_idx <= r_bit_idx + 1'b1;
              if (r_bit_idx == LAST_BIT) r_state <= STOP;
            end
          end
          STOP: begin
            r_cnt <= w_cnt_nxt;
            if (r_cnt == LAST_CNT) begin
              r_cnt   <= '0;
              r_state <= IDLE;
              if (!w_rx_s) begin
                r_frame_err <= 1'b1;
              end else if (w_free) begin
                r_data_out   <= r_shift;
                r_data_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: tick-timestamp reference model compared every cycle, plus literal scenario checks.
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       rst, tick, en, rx, ready;
  logic [7:0] data_out;
  logic       data_valid, frame_err, overrun;

  int checks = 0;
  int failures = 0;
  int mode = 1;          // ready behaviour: 0 low, 1 high, 2 random
  bit chk_on = 1'b0;
  int tick_no = 0;

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sample_tick(tick),
    .i_en         (en),
    .i_rx         (rx),
    .o_data_out   (data_out),
    .o_data_valid (data_valid),
    .i_data_ready (ready),
    .o_frame_err  (frame_err),
    .o_overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       ready = 1'b0;
        1:       ready = 1'b1;
        default: ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(posedge clk) if (tick) tick_no++;

  task automatic cmp(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures < 40) $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame position is (tick index - detection tick), bits are
  // taken at the fixed offsets 7 + 16*(k+1) and the stop bit at 7 + 144.
  bit         m_s1, m_s2, m_prev, m_busy, m_valid, m_ferr, m_ovr;
  logic [7:0] m_data, m_bits;
  int         m_n, m_t0;

  always @(posedge clk) begin
    bit rs;
    int d;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    if (rst) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_prev = 1'b1; m_busy = 1'b0;
      m_valid = 1'b0; m_data = 8'h00; m_n = 0;
    end else begin
      rs   = m_s2;
      m_s2 = m_s1;
      m_s1 = rx;
      if (m_valid && ready) m_valid = 1'b0;
      if (!en) m_busy = 1'b0;
      if (tick) begin
        m_n++;
        if (en) begin
          if (m_busy) begin
            d = m_n - m_t0;
            if (d == 151) begin
              m_busy = 1'b0;
              if (!rs) m_ferr = 1'b1;
              else if (!m_valid) begin m_valid = 1'b1; m_data = m_bits; end
              else m_ovr = 1'b1;
            end else if (d == 7) begin
              if (rs) m_busy = 1'b0;
            end else if (d > 7 && (d - 7) % 16 == 0) begin
              m_bits[(d - 7) / 16 - 1] = rs;
            end
          end else if (m_prev && !rs) begin
            m_busy = 1'b1;
            m_t0   = m_n;
          end
        end
        m_prev = rs;
      end
    end
  end

  // Per-cycle comparison and event log.
  int         n_rise = 0, n_ferr = 0, n_ovr = 0, rise_tick = 0;
  bit         pv = 1'b0;
  logic [7:0] rq[$];

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("data_valid", int'(data_valid), int'(m_valid));
      cmp("data_out", int'(data_out), int'(m_data));
      cmp("frame_err", int'(frame_err), int'(m_ferr));
      cmp("overrun", int'(overrun), int'(m_ovr));
      if (data_valid === 1'b1 && !pv) begin
        n_rise++;
        rq.push_back(data_out);
        rise_tick = tick_no;
      end
      pv = (data_valid === 1'b1);
      if (frame_err === 1'b1) n_ferr++;
      if (overrun === 1'b1) n_ovr++;
    end
  end

  task automatic next_tick();
    do @(posedge clk); while (tick !== 1'b1);
    #2;
  endtask

  task automatic idle(int n);
    rx = 1'b1;
    repeat (n) next_tick();
  endtask

  task automatic send(logic [7:0] b, bit stop, int abort_at = -1, int abort_len = 0, bit use_rst = 1'b0);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 160; i++) begin
      rx = f[i / 16];
      if (i == abort_at) begin if (use_rst) rst = 1'b1; else en = 1'b0; end
      if (i == abort_at + abort_len) begin rst = 1'b0; en = 1'b1; end
      next_tick();
    end
    rst = 1'b0;
    en  = 1'b1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=done");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, r0, f0, o0;
    rst = 1'b1; en = 1'b1; rx = 1'b1;
    repeat (2) @(posedge clk);
    chk_on = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    cmp("reset data_valid", int'(data_valid), 0);
    cmp("reset data_out", int'(data_out), 0);
    cmp("reset frame_err", int'(frame_err), 0);
    cmp("reset overrun", int'(overrun), 0);
    next_tick();
    rst = 1'b0;
    idle(20);

    // Loopback 0xB4, with start-edge-to-valid latency in ticks.
    r0 = n_rise; f0 = n_ferr; t0 = tick_no;
    send(8'hB4, 1'b1);
    idle(20);
    cmp("loopback beats", n_rise - r0, 1);
    cmp("loopback data", int'(rq[rq.size() - 1]), 8'hB4);
    cmp("loopback latency ticks", rise_tick - t0, 152);
    cmp("loopback frame_err", n_ferr - f0, 0);

    // Back-to-back frames with no idle gap.
    r0 = n_rise; rq.delete();
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    idle(20);
    cmp("b2b beats", n_rise - r0, 2);
    if (rq.size() == 2) begin
      cmp("b2b first", int'(rq[0]), 8'hA5);
      cmp("b2b second", int'(rq[1]), 8'h3C);
    end else cmp("b2b queue size", rq.size(), 2);

    // Short low pulse is rejected as a glitch.
    r0 = n_rise; f0 = n_ferr;
    rx = 1'b0;
    repeat (4) next_tick();
    idle(200);
    cmp("glitch beats", n_rise - r0, 0);
    cmp("glitch frame_err", n_ferr - f0, 0);

    // Stop bit low, then the line held low (break).
    r0 = n_rise; f0 = n_ferr;
    send(8'h55, 1'b0);
    rx = 1'b0;
    repeat (400) next_tick();
    idle(40);
    cmp("ferr pulses", n_ferr - f0, 1);
    cmp("ferr beats", n_rise - r0, 0);

    // Overrun with the consumer stalled.
    mode = 0; o0 = n_ovr;
    idle(10);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    idle(20);
    cmp("overrun pulses", n_ovr - o0, 1);
    cmp("overrun kept byte", int'(data_out), 8'h11);
    cmp("overrun valid held", int'(data_valid), 1);
    mode = 1;
    @(posedge clk);
    @(negedge clk);
    cmp("accept valid before", int'(data_valid), 1);
    @(negedge clk);
    cmp("accept valid after", int'(data_valid), 0);
    idle(10);

    // Abort by enable and by reset during data bit 3, then a clean frame.
    for (int k = 0; k < 2; k++) begin
      r0 = n_rise; rq.delete();
      send(8'hF0, 1'b1, 72, 200, k[0]);
      idle(20);
      send(8'h81, 1'b1);
      idle(20);
      cmp(k == 0 ? "en abort beats" : "rst abort beats", n_rise - r0, 1);
      if (rq.size() > 0) cmp(k == 0 ? "en abort data" : "rst abort data", int'(rq[rq.size() - 1]), 8'h81);
    end

    // Randomised traffic: gaps, glitches, bad stops, enable drops, random ready.
    for (int it = 0; it < 30; it++) begin
      int kind;
      mode = $urandom_range(0, 2);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        rx = 1'b0;
        repeat ($urandom_range(1, 7)) next_tick();
      end else if (kind == 1) begin
        send(8'($urandom), 1'b1, $urandom_range(0, 159), $urandom_range(1, 40));
      end else begin
        send(8'($urandom), ($urandom_range(0, 7) != 0));
      end
      idle($urandom_range(0, 24));
    end

    mode = 1;
    idle(200);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
